dmem_model: RTL and testbench

- Parametrised, byte-addressable data-memory model used behind dtcore32's DMEM port in simulation and formal harnesses.
- Replaces the fixed 1 KiB zero-latency array with a request/response handshake, programmable read/write latency, back-pressure, and out-of-range error reporting.
- One outstanding transaction at a time.

---
 rtl/dmem_model_pkg.sv | 24 ++
 rtl/dmem_model_if.sv | 30 +++
 rtl/dmem_byte_array.sv | 48 ++++
 rtl/dmem_model.sv | 137 +++++++++++++
 tb/tb_dmem_model.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_model_pkg.sv
`default_nettype none
// ============================================================================
// dmem_model_pkg : shared types, constants and wrap helper for dmem_model
// Rev 1.0
// ============================================================================
package dmem_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned BYTE_LANES = 4;

  // mem_bytes is a power of two, so masking is the modulo
  function automatic logic [31:0] lane_addr(input logic [31:0] addr,
                                            input int unsigned k,
                                            input int unsigned mem_bytes);
    lane_addr = (addr + 32'(k)) & 32'(mem_bytes - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_model_if.sv
`default_nettype none
// ============================================================================
// dmem_model_if : request/response bus between a core and dmem_model
// Rev 1.0
// ============================================================================
interface dmem_model_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_wmask_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wmask_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wmask_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
// dmem_byte_array : MEM_BYTES x 8 storage, 4 read lanes, 4 masked write lanes
// Rev 1.0
// ============================================================================
module dmem_byte_array
  import dmem_model_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned INIT_ZERO = 1,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic                            clk_i,
  input  logic [BYTE_LANES-1:0][AW-1:0]   addr_i,
  input  logic [BYTE_LANES-1:0]           we_i,
  input  logic [BYTE_LANES-1:0][7:0]      wdata_i,
  output logic [BYTE_LANES-1:0][7:0]      rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];

  // Contents are deliberately outside the reset domain
  generate
    if (INIT_ZERO != 0) begin : g_init
      initial begin
        for (int i = 0; i < int'(MEM_BYTES); i++) begin
          mem_q[i] = 8'h00;
        end
      end
    end
  endgenerate

  always @(posedge clk_i) begin
    for (int k = 0; k < int'(BYTE_LANES); k++) begin
      if (we_i[k]) begin
        mem_q[addr_i[k]] <= wdata_i[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < int'(BYTE_LANES); k++) begin : g_rd
      assign rdata_o[k] = mem_q[addr_i[k]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_model.sv
`default_nettype none
// ============================================================================
// dmem_model : latency-programmable byte-addressable data memory with handshake
// Rev 1.0
// ============================================================================
module dmem_model
  import dmem_model_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmem_model_if.slave  bus,
  output logic         busy_o
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                           w_access;
  logic                           w_err;
  logic [BYTE_LANES-1:0][AW-1:0]  w_lane_addr;
  logic [BYTE_LANES-1:0]          w_bwe;
  logic [BYTE_LANES-1:0][7:0]     w_wlanes;
  logic [BYTE_LANES-1:0][7:0]     w_rlanes;

  // 33-bit compare so addresses near 2^32 cannot wrap past the check
  assign w_err = (WRAP == 0) && (({1'b0, addr_q} + 33'd3) >= 33'(MEM_BYTES));

  generate
    for (genvar k = 0; k < int'(BYTE_LANES); k++) begin : g_lane
      logic [31:0] w_full;
      logic        w_unused_hi;
      assign w_full         = lane_addr(addr_q, k, MEM_BYTES);
      assign w_lane_addr[k] = w_full[AW-1:0];
      assign w_unused_hi    = ^w_full[31:AW];
      assign w_bwe[k]       = rst_ni && w_access && we_q && !w_err && wmask_q[k];
    end
  endgenerate

  assign w_wlanes = wdata_q;

  dmem_byte_array #(
    .MEM_BYTES (MEM_BYTES),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk_i   (clk_i),
    .addr_i  (w_lane_addr),
    .we_i    (w_bwe),
    .wdata_i (w_wlanes),
    .rdata_o (w_rlanes)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    w_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          we_d    = bus.req_we_i;
          wmask_d = bus.req_wmask_i;
          wdata_d = bus.req_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          w_access = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_access) begin
      err_d   = w_err;
      rdata_d = (we_q || w_err) ? 32'h0 : w_rlanes;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wmask_q <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign busy_o          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_model.sv
`default_nettype none
// ============================================================================
// tb_dmem_model : scoreboard bench, dut0 = LATENCY 1 / WRAP 1, dut1 = LATENCY 4 / WRAP 0
// Rev 1.0
// ============================================================================
module tb_dmem_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       vld, we, rrdy;
  logic [1:0][31:0] addr, wd;
  logic [1:0][3:0]  wm;
  logic [1:0]       rdy, rv, er, bsy;
  logic [1:0][31:0] rd;

  dmem_model_if bus0 ();
  dmem_model_if bus1 ();

  assign bus0.req_valid_i = vld[0];
  assign bus0.req_addr_i  = addr[0];
  assign bus0.req_we_i    = we[0];
  assign bus0.req_wmask_i = wm[0];
  assign bus0.req_wdata_i = wd[0];
  assign bus0.rsp_ready_i = rrdy[0];
  assign rdy[0] = bus0.req_ready_o;
  assign rv[0]  = bus0.rsp_valid_o;
  assign rd[0]  = bus0.rsp_rdata_o;
  assign er[0]  = bus0.rsp_err_o;

  assign bus1.req_valid_i = vld[1];
  assign bus1.req_addr_i  = addr[1];
  assign bus1.req_we_i    = we[1];
  assign bus1.req_wmask_i = wm[1];
  assign bus1.req_wdata_i = wd[1];
  assign bus1.rsp_ready_i = rrdy[1];
  assign rdy[1] = bus1.req_ready_o;
  assign rv[1]  = bus1.rsp_valid_o;
  assign rd[1]  = bus1.rsp_rdata_o;
  assign er[1]  = bus1.rsp_err_o;

  dmem_model #(.MEM_BYTES(1024), .LATENCY(1), .WRAP(1), .INIT_ZERO(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .bus(bus0.slave), .busy_o(bsy[0]));
  dmem_model #(.MEM_BYTES(1024), .LATENCY(4), .WRAP(0), .INIT_ZERO(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .bus(bus1.slave), .busy_o(bsy[1]));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mdl [2][1024];
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] e0, e1;

  function automatic int lat(input int s);
    return (s == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte array with modulo / range rules applied directly
  task automatic model_access(input int s, input logic [31:0] a, input logic w,
                              input logic [3:0] m, input logic [31:0] d,
                              output logic [32:0] exp);
    longint unsigned last;
    logic [31:0] r;
    int b;
    last = longint'(a) + 3;
    r = 32'h0;
    if (s == 1 && last >= 1024) begin
      exp = {1'b1, 32'h0};
    end else begin
      for (int k = 0; k < 4; k++) begin
        b = int'((longint'(a) + k) % 1024);
        if (w) begin
          if (m[k]) mdl[s][b] = d[8*k +: 8];
        end else begin
          r[8*k +: 8] = mdl[s][b];
        end
      end
      exp = {1'b0, w ? 32'h0 : r};
    end
  endtask

  task automatic xact(input int s, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] d, input int bp);
    logic [32:0] e;
    logic [31:0] hold_rd;
    logic        hold_er;
    int k;
    @(negedge clk);
    vld[s] = 1'b1; addr[s] = a; we[s] = w; wm[s] = m; wd[s] = d;
    chk("req_ready_idle", {31'b0, rdy[s]}, 32'd1);
    @(posedge clk);
    model_access(s, a, w, m, d, e);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    #1;
    vld[s] = 1'b0; addr[s] = $urandom; we[s] = 1'($urandom); wm[s] = 4'($urandom); wd[s] = $urandom;
    k = 0;
    while (!rv[s] && k < 40) begin
      chk("busy_wait", {30'b0, bsy[s], rdy[s]}, 32'd2);
      @(posedge clk); #1; k++;
    end
    chk("latency", k, lat(s));
    if (!rv[s]) return;
    hold_rd = rd[s];
    hold_er = er[s];
    repeat (bp) begin
      @(posedge clk); #1;
      chk("bp_hold", {rd[s] ^ hold_rd}, 32'h0);
      chk("bp_flags", {28'b0, rv[s], rdy[s], bsy[s], er[s] ^ hold_er}, 32'hA);
    end
    rrdy[s] = 1'b1;
    @(posedge clk); #1;
    rrdy[s] = 1'b0;
    chk("post_hs_flags", {29'b0, rdy[s], rv[s], bsy[s]}, 32'h4);
    chk("post_hs_rdata_kept", rd[s], hold_rd);
  endtask

  always @(negedge clk) begin
    if (rv[0] && rrdy[0]) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp0_unexpected: got response expected none");
      end else begin
        e0 = q0.pop_front();
        chk("rsp0_rdata", rd[0], e0[31:0]);
        chk("rsp0_err", {31'b0, er[0]}, {31'b0, e0[32]});
      end
    end
    if (rv[1] && rrdy[1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp1_unexpected: got response expected none");
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_rdata", rd[1], e1[31:0]);
        chk("rsp1_err", {31'b0, er[1]}, {31'b0, e1[32]});
      end
    end
  end

  task automatic chk_reset_outs(input int s, input string name);
    chk(name, {rd[s]}, 32'h0);
    chk(name, {28'b0, rdy[s], rv[s], er[s], bsy[s]}, 32'h8);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mdl[s][i] = 8'h00;
    rst_n = 2'b00; vld = '0; we = '0; rrdy = '0; addr = '0; wd = '0; wm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs(0, "reset_in0");
    chk_reset_outs(1, "reset_in1");
    @(negedge clk);
    rst_n = 2'b11;
    @(posedge clk); #1;
    chk_reset_outs(0, "reset_out0");
    chk_reset_outs(1, "reset_out1");

    // Full-word, byte-lane and wrap-around cases on the wrapping instance
    xact(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0);
    xact(0, 32'h10, 1'b0, 4'h0, 32'h0, 0);
    xact(0, 32'h10, 1'b1, 4'h5, 32'h11223344, 1);
    xact(0, 32'h10, 1'b0, 4'hF, 32'h0, 0);
    xact(0, 32'h3FE, 1'b1, 4'hF, 32'hA1B2C3D4, 0);
    xact(0, 32'h0, 1'b0, 4'h0, 32'h0, 0);
    xact(0, 32'h3FE, 1'b0, 4'h0, 32'h0, 2);
    xact(0, 32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 0);
    xact(0, 32'h10, 1'b0, 4'h0, 32'h0, 0);

    // Range errors and back-pressure on the latency-4 instance
    xact(1, 32'h3FC, 1'b1, 4'hF, 32'h55667788, 0);
    xact(1, 32'h3FD, 1'b0, 4'h0, 32'h0, 0);
    xact(1, 32'h3FD, 1'b1, 4'hF, 32'hCAFEF00D, 0);
    xact(1, 32'hFFFFFFFE, 1'b0, 4'h0, 32'h0, 0);
    xact(1, 32'h3FC, 1'b0, 4'h0, 32'h0, 2);

    // Abandon a write mid-WAIT with an asynchronous reset
    @(negedge clk);
    vld[1] = 1'b1; addr[1] = 32'h3FC; we[1] = 1'b1; wm[1] = 4'hF; wd[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, bsy[1]}, 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_outs(1, "async_reset");
    @(negedge clk);
    rst_n[1] = 1'b1;
    xact(1, 32'h3FC, 1'b0, 4'h0, 32'h0, 0);

    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 1023));
      else if (r < 9) a = 32'($urandom_range(1018, 1027));
      else            a = $urandom;
      xact($urandom_range(0, 1), a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
